// File: rtl/perf_pkg.sv
// Shared types and constants for the pipeline performance monitor.
package perf_pkg;

    // Monitor FSM encoding; the numeric values are visible on state_o.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } perf_state_e;

    // Conventional event channel assignment used by the CPU top.
    localparam int EV_STALL  = 0;
    localparam int EV_FLUSH  = 1;
    localparam int EV_RETIRE = 2;
    localparam int EV_BRANCH = 3;

endpackage

// File: rtl/perf_counter_ch.sv
// One performance counter channel: increment, synchronous clear,
// saturate-or-wrap at all-ones and a sticky overflow flag.
module perf_counter_ch #(
    parameter int CNT_W    = 32,
    parameter bit SATURATE = 1'b1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             clr_i,
    input  logic             inc_i,
    output logic [CNT_W-1:0] cnt_o,
    output logic             ovf_o
);

    // Counter and sticky overflow; clear has priority over increment.
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            cnt_o <= '0;
            ovf_o <= 1'b0;
        end else if (clr_i) begin
            cnt_o <= '0;
            ovf_o <= 1'b0;
        end else if (inc_i) begin
            if (&cnt_o) begin
                ovf_o <= 1'b1;
                cnt_o <= SATURATE ? cnt_o : '0;
            end else begin
                cnt_o <= cnt_o + 1'b1;
            end
        end
    end

endmodule

// File: rtl/pipeline_perf_monitor.sv
// Performance monitor for the pipelined CPU: counts run cycles and qualified
// pipeline events, stops after a cycle budget and serves one counter per read.
module pipeline_perf_monitor
    import perf_pkg::*;
#(
    parameter int NUM_EVENTS = 4,
    parameter int CNT_W      = 32,
    parameter int MAX_CYCLES = 64,
    parameter bit SATURATE   = 1'b1
) (
    input  logic                              clk_i,
    input  logic                              rst_i,
    input  logic                              start_i,
    input  logic                              clear_i,
    input  logic [NUM_EVENTS-1:0]             event_i,
    input  logic                              rd_en_i,
    input  logic [$clog2(NUM_EVENTS+1)-1:0]   rd_sel_i,
    output logic [CNT_W-1:0]                  rd_data_o,
    output logic                              rd_valid_o,
    output logic                              rd_err_o,
    output logic [CNT_W-1:0]                  cycle_o,
    output logic [1:0]                        state_o,
    output logic                              done_o,
    output logic [NUM_EVENTS:0]               ovf_o
);

    localparam int SEL_W   = $clog2(NUM_EVENTS + 1);
    localparam int NUM_CNT = NUM_EVENTS + 1;
    localparam int CYC_IDX = NUM_EVENTS;
    localparam logic [CNT_W:0] BUDGET = (CNT_W + 1)'(MAX_CYCLES);

    perf_state_e      state_q, state_d;
    logic             count_en;
    logic             budget_hit;
    logic [NUM_CNT-1:0] ch_inc;
    logic [CNT_W-1:0] cnt [NUM_CNT];
    logic [CNT_W-1:0] rd_mux;
    logic             rd_oob;

    // The budget is met when this edge's increment lands the cycle count on MAX_CYCLES.
    assign budget_hit = (MAX_CYCLES != 0) && (({1'b0, cnt[CYC_IDX]} + 1'b1) == BUDGET);

    // State register.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    // Next-state and count enable; clear overrides start, budget and events.
    // NOTE: every output of this block is defaulted first so no latch is inferred.
    always_comb begin
        state_d  = state_q;
        count_en = 1'b0;
        if (clear_i) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: if (start_i) state_d = ST_RUN;
                ST_RUN: begin
                    count_en = 1'b1;
                    if (budget_hit)    state_d = ST_DONE;
                    else if (!start_i) state_d = ST_IDLE;
                end
                ST_DONE: state_d = ST_DONE;
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // Event channels followed by the cycle counter in the last slot.
    for (genvar k = 0; k < NUM_CNT; k++) begin : g_ch
        if (k < NUM_EVENTS) begin : g_ev
            assign ch_inc[k] = count_en & event_i[k];
        end else begin : g_cyc
            assign ch_inc[k] = count_en;
        end

        perf_counter_ch #(
            .CNT_W    (CNT_W),
            .SATURATE (SATURATE)
        ) u_ch (
            .clk_i (clk_i),
            .rst_i (rst_i),
            .clr_i (clear_i),
            .inc_i (ch_inc[k]),
            .cnt_o (cnt[k]),
            .ovf_o (ovf_o[k])
        );
    end

    // Read mux over pre-edge counter values; out-of-range selects read as zero.
    always_comb begin
        rd_mux = '0;
        rd_oob = 1'b1;
        for (int i = 0; i < NUM_CNT; i++) begin
            if (rd_sel_i == SEL_W'(i)) begin
                rd_mux = cnt[i];
                rd_oob = 1'b0;
            end
        end
    end

    // Registered read response; data holds between reads.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            rd_data_o  <= '0;
            rd_valid_o <= 1'b0;
            rd_err_o   <= 1'b0;
        end else begin
            rd_valid_o <= rd_en_i;
            rd_err_o   <= rd_en_i & rd_oob;
            if (rd_en_i) rd_data_o <= rd_mux;
        end
    end

    assign cycle_o = cnt[CYC_IDX];
    assign state_o = state_q;
    assign done_o  = (state_q == ST_DONE);

endmodule
